// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: halt / slow run / fast run / single-step, with a program-end stop.
// Latency: mode_sel reaches run_state 3 cycles after it changes; run pulses arrive D cycles after
//          entering S_RUN; a step pulse arrives 1 cycle after an accepted button press.
// Backpressure: none; halt_req overrides everything in its cycle and holds S_STOP until resume.
//
// Ports:
//   clk_in1   in   1  board clock, the only clock
//   rst       in   1  synchronous active-high reset
//   mode_sel  in   2  asynchronous switch: 00 halt, 01 slow run, 10 fast run, 11 single-step
//   step_btn  in   1  asynchronous raw push button, active-high
//   halt_req  in   1  single-cycle stop request from the CPU
//   resume    in   1  single-cycle release of a halt_req stop
//   cpu_ce    out  1  registered single-cycle CPU clock-enable
//   run_state out  2  FSM state (00 halt, 01 run, 10 step, 11 stop)
//   ce_count  out 32  cpu_ce pulses since reset, wrapping
module cpu_clk_ctrl #(
    parameter int unsigned DIV_FAST = 10,
    parameter int unsigned DIV_SLOW = 10000,
    parameter int unsigned DEBOUNCE = 200000
) (
    input  logic        clk_in1,
    input  logic        rst,
    input  logic [1:0]  mode_sel,
    input  logic        step_btn,
    input  logic        halt_req,
    input  logic        resume,
    output logic        cpu_ce,
    output logic [1:0]  run_state,
    output logic [31:0] ce_count
);

    localparam int unsigned DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
    localparam int unsigned PW      = $clog2(DIV_MAX + 1);
    localparam int unsigned DW      = $clog2(DEBOUNCE + 1);

    localparam logic [PW-1:0] FAST_LAST = PW'(DIV_FAST - 1);
    localparam logic [PW-1:0] SLOW_LAST = PW'(DIV_SLOW - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_STOP = 2'b11
    } state_e;

    // Synchronizers; mode_q is the synchronized mode one cycle later, used to spot run-mode changes.
    logic [1:0]    mode_s1_q;
    logic [1:0]    mode_s2_q;
    logic [1:0]    mode_q;
    logic          step_s1_q;
    logic          step_s2_q;

    logic          btn_lvl_q;
    logic          btn_lvl_d;
    logic          btn_prev_q;
    logic [DW-1:0] db_cnt_q;
    logic [DW-1:0] db_cnt_d;
    logic          step_rise;

    state_e        state_q;
    state_e        state_d;
    state_e        mode_state;

    logic [PW-1:0] per_cnt_q;
    logic [PW-1:0] per_cnt_d;
    logic [PW-1:0] per_last;

    logic          cpu_ce_q;
    logic          cpu_ce_d;
    logic [31:0]   ce_count_q;
    logic [31:0]   ce_count_d;

    // Debounce: the accepted level only follows the synchronized button after DEBOUNCE
    // consecutive differing samples; a matching sample restarts the count.
    always_comb begin
        btn_lvl_d = btn_lvl_q;
        db_cnt_d  = '0;
        if (step_s2_q != btn_lvl_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_lvl_d = step_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign step_rise = btn_lvl_q & ~btn_prev_q;

    always_comb begin
        mode_state = S_STEP;
        case (mode_s2_q)
            2'b00:   mode_state = S_HALT;
            2'b01:   mode_state = S_RUN;
            2'b10:   mode_state = S_RUN;
            default: mode_state = S_STEP;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (halt_req) begin
            state_d = S_STOP;
        end else if (state_q == S_STOP) begin
            if (resume) begin
                state_d = mode_state;
            end
        end else begin
            state_d = mode_state;
        end
    end

    // mode_q is always the mode that put the FSM into S_RUN, so it selects the period in force.
    assign per_last = (mode_q == 2'b01) ? SLOW_LAST : FAST_LAST;

    always_comb begin
        cpu_ce_d  = 1'b0;
        per_cnt_d = '0;
        if ((state_q == S_RUN) && !halt_req) begin
            if (per_cnt_q == per_last) begin
                cpu_ce_d = 1'b1;
            end else if ((state_d == S_RUN) && (mode_s2_q == mode_q)) begin
                // Leaving S_RUN or switching slow/fast restarts the period from zero.
                per_cnt_d = per_cnt_q + 1'b1;
            end
        end
        if ((state_q == S_STEP) && step_rise && !halt_req) begin
            cpu_ce_d = 1'b1;
        end
        ce_count_d = ce_count_q + {31'b0, cpu_ce_d};
    end

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            mode_s1_q  <= '0;
            mode_s2_q  <= '0;
            mode_q     <= '0;
            step_s1_q  <= 1'b0;
            step_s2_q  <= 1'b0;
            btn_lvl_q  <= 1'b0;
            btn_prev_q <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= S_HALT;
            per_cnt_q  <= '0;
            cpu_ce_q   <= 1'b0;
            ce_count_q <= '0;
        end else begin
            mode_s1_q  <= mode_sel;
            mode_s2_q  <= mode_s1_q;
            mode_q     <= mode_s2_q;
            step_s1_q  <= step_btn;
            step_s2_q  <= step_s1_q;
            btn_lvl_q  <= btn_lvl_d;
            btn_prev_q <= btn_lvl_q;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            cpu_ce_q   <= cpu_ce_d;
            ce_count_q <= ce_count_d;
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign run_state = state_q;
    assign ce_count  = ce_count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl with a cycle-level behavioural reference model.
// Latency: model predicts each output for the cycle after every clock edge.
// Backpressure: n/a; directed scenarios followed by randomized switch/button/halt traffic.
module tb_cpu_clk_ctrl;

    localparam int DF = 10;
    localparam int DS = 40;
    localparam int DB = 4;

    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_STOP = 3;

    logic        clk_in1 = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode_sel = 2'b10;
    logic        step_btn = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        cpu_ce;
    logic [1:0]  run_state;
    logic [31:0] ce_count;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    logic prev_ce = 1'b0;

    // Reference model state
    longint      edge_n = 0;
    longint      run_start = 0;
    logic [1:0]  m_run_mode = 2'b00;
    int          m_st = M_HALT;
    bit          m_ce = 1'b0;
    logic [31:0] m_cnt = '0;
    logic [1:0]  mode_hist[$];
    bit          btn_hist[$];
    bit          diff_win[$];
    bit          m_acc = 1'b0;
    bit          m_pend = 1'b0;

    cpu_clk_ctrl #(.DIV_FAST(DF), .DIV_SLOW(DS), .DEBOUNCE(DB)) dut (
        .clk_in1  (clk_in1),
        .rst      (rst),
        .mode_sel (mode_sel),
        .step_btn (step_btn),
        .halt_req (halt_req),
        .resume   (resume),
        .cpu_ce   (cpu_ce),
        .run_state(run_state),
        .ce_count (ce_count)
    );

    always #5 clk_in1 = ~clk_in1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mode_to_state(input logic [1:0] m);
        if (m == 2'b00) return M_HALT;
        if (m == 2'b11) return M_STEP;
        return M_RUN;
    endfunction

    function automatic longint period_of(input logic [1:0] m);
        return (m == 2'b01) ? longint'(DS) : longint'(DF);
    endfunction

    // One clock edge of the reference: inputs are what the DUT samples at this edge.
    task automatic model_step();
        logic [1:0] eff;
        bit         s;
        bit         pulse;
        int         nst;
        edge_n++;
        if (rst) begin
            m_st = M_HALT; m_ce = 1'b0; m_cnt = '0;
            mode_hist.delete(); btn_hist.delete(); diff_win.delete();
            m_acc = 1'b0; m_pend = 1'b0;
            return;
        end
        // Both asynchronous inputs are seen two samples late; zeros until history fills.
        eff = 2'b00;
        if (mode_hist.size() == 2) eff = mode_hist.pop_front();
        mode_hist.push_back(mode_sel);
        s = 1'b0;
        if (btn_hist.size() == 2) s = btn_hist.pop_front();
        btn_hist.push_back(step_btn);

        pulse = 1'b0;
        if (m_st == M_RUN && !halt_req && ((edge_n - run_start) % period_of(m_run_mode)) == 0)
            pulse = 1'b1;
        if (m_st == M_STEP && m_pend && !halt_req)
            pulse = 1'b1;

        m_pend = 1'b0;
        if (s == m_acc) begin
            diff_win.delete();
        end else begin
            diff_win.push_back(s);
            if (diff_win.size() == DB) begin
                m_acc = s;
                m_pend = s;
                diff_win.delete();
            end
        end

        if (halt_req)           nst = M_STOP;
        else if (m_st == M_STOP) nst = resume ? mode_to_state(eff) : M_STOP;
        else                    nst = mode_to_state(eff);

        if (nst == M_RUN && (m_st != M_RUN || eff != m_run_mode)) begin
            run_start  = edge_n;
            m_run_mode = eff;
        end
        m_st = nst;
        m_ce = pulse;
        if (pulse) m_cnt = m_cnt + 32'd1;
    endtask

    initial forever begin
        @(posedge clk_in1);
        model_step();
    end

    initial forever begin
        @(negedge clk_in1);
        if (chk_en) begin
            chk("cpu_ce", 32'(cpu_ce), 32'(m_ce));
            chk("run_state", 32'(run_state), 32'(m_st));
            chk("ce_count", ce_count, m_cnt);
            chk("no_back_to_back", 32'(cpu_ce & prev_ce), 32'd0);
            prev_ce = cpu_ce;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in1);
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim);
        int k = 0;
        while (run_state != s && k < lim) begin
            @(negedge clk_in1);
            k++;
        end
        if (run_state != s) chk("wait_state", 32'(run_state), 32'(s));
    endtask

    task automatic wait_ce(input int lim);
        int k = 0;
        do begin
            @(negedge clk_in1);
            k++;
        end while (cpu_ce !== 1'b1 && k < lim);
        if (cpu_ce !== 1'b1) chk("wait_ce", 32'(cpu_ce), 32'd1);
    endtask

    initial begin
        logic [31:0] c0;
        int          mode_hold;
        int          btn_hold;
        bit          bounce[6];

        // Reset with fast run already selected
        cyc(3);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_ce", 32'(cpu_ce), 32'd0);
        chk("reset_state", 32'(run_state), 32'(M_HALT));
        chk("reset_count", ce_count, 32'd0);

        // Fast run: 100 cycles in S_RUN give 10 pulses
        wait_state(2'b01, 10);
        cyc(100);
        chk("fast_count", ce_count, 32'd10);
        chk("fast_last_ce", 32'(cpu_ce), 32'd1);

        // Switch to slow run mid-period: the counter restarts under the slow period
        cyc(4);
        mode_sel = 2'b01;
        c0 = ce_count;
        cyc(42);
        chk("slow_quiet", ce_count, c0);
        cyc(1);
        chk("slow_first_ce", 32'(cpu_ce), 32'd1);
        cyc(40);
        chk("slow_second_ce", 32'(cpu_ce), 32'd1);
        chk("slow_count", ce_count, c0 + 32'd2);

        // halt_req on the last count of a fast period suppresses that pulse
        mode_sel = 2'b10;
        wait_ce(60);
        cyc(9);
        halt_req = 1'b1;
        cyc(1);
        halt_req = 1'b0;
        chk("halt_no_ce", 32'(cpu_ce), 32'd0);
        chk("halt_state", 32'(run_state), 32'(M_STOP));
        c0 = ce_count;
        cyc(3);
        resume = 1'b1;
        cyc(1);
        resume = 1'b0;
        chk("resume_state", 32'(run_state), 32'(M_RUN));
        cyc(9);
        chk("resume_quiet", ce_count, c0);
        cyc(1);
        chk("resume_first_ce", 32'(cpu_ce), 32'd1);

        // halt_req beats resume in S_STOP; resume in S_RUN is ignored
        halt_req = 1'b1;
        cyc(1);
        halt_req = 1'b0;
        chk("stop_enter", 32'(run_state), 32'(M_STOP));
        cyc(2);
        halt_req = 1'b1;
        resume = 1'b1;
        cyc(1);
        halt_req = 1'b0;
        resume = 1'b0;
        chk("halt_beats_resume", 32'(run_state), 32'(M_STOP));
        cyc(2);
        resume = 1'b1;
        cyc(1);
        resume = 1'b0;
        chk("stop_release", 32'(run_state), 32'(M_RUN));
        cyc(3);
        resume = 1'b1;
        cyc(1);
        resume = 1'b0;
        chk("resume_in_run", 32'(run_state), 32'(M_RUN));

        // Single-step with a bouncing press, then release and press again
        mode_sel = 2'b11;
        wait_state(2'b10, 10);
        c0 = ce_count;
        bounce = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        foreach (bounce[i]) begin
            step_btn = bounce[i];
            cyc(1);
        end
        step_btn = 1'b1;
        cyc(20);
        chk("step_one_pulse", ce_count, c0 + 32'd1);
        step_btn = 1'b0;
        cyc(10);
        chk("step_release", ce_count, c0 + 32'd1);
        step_btn = 1'b1;
        cyc(10);
        chk("step_second", ce_count, c0 + 32'd2);
        step_btn = 1'b0;
        cyc(10);

        // Counter wrap via backdoor preload, then reset right where a pulse is due
        mode_sel = 2'b10;
        wait_state(2'b01, 10);
        wait_ce(30);
        #1;
        dut.ce_count_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        wait_ce(30);
        chk("wrap_count", ce_count, 32'd0);
        cyc(9);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrun_rst_ce", 32'(cpu_ce), 32'd0);
        chk("midrun_rst_state", 32'(run_state), 32'(M_HALT));
        chk("midrun_rst_count", ce_count, 32'd0);

        // Randomized traffic against the model
        mode_hold = 0;
        btn_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in1);
            if (mode_hold == 0) begin
                mode_sel  = 2'($urandom_range(3, 0));
                mode_hold = int'($urandom_range(120, 5));
            end else begin
                mode_hold--;
            end
            if (btn_hold == 0) begin
                step_btn = ~step_btn;
                btn_hold = int'($urandom_range(9, 0));
            end else begin
                btn_hold--;
            end
            halt_req = ($urandom_range(59, 0) == 0);
            resume   = ($urandom_range(14, 0) == 0);
            rst      = ($urandom_range(799, 0) == 0);
        end
        halt_req = 1'b0;
        resume = 1'b0;
        rst = 1'b0;
        cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
